// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared state/grant codes and sizing helpers for the memory port arbiter
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'b00,
        ARB_BUSY = 2'b01,
        ARB_RESP = 2'b10
    } arb_state_t;

    typedef enum logic {
        GNT_IF = 1'b0,
        GNT_D  = 1'b1
    } arb_gnt_t;

    localparam int DEF_MAX_D_RUN = 4;
    localparam int DEF_TIMEOUT   = 255;

    // Bits needed to hold values 0..n inclusive.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/mem_arb_timer.sv
// rtl/mem_arb_timer.sv - loadable up-counter with clear/enable and terminal-count flag
module mem_arb_timer #(
    parameter int WIDTH    = 8,
    parameter int TERMINAL = 254
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             tc
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (en) begin
            count_q <= count_q + WIDTH'(1);
        end
    end

    assign tc = (count_q == WIDTH'(TERMINAL));

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one MIO bus port between instruction fetch and data access
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int MAX_D_RUN = DEF_MAX_D_RUN,
    parameter int TIMEOUT   = DEF_TIMEOUT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_done,
    output logic        if_stall,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wtype,
    output logic [31:0] d_rdata,
    output logic        d_done,
    output logic        d_stall,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wtype,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ready,
    output logic        bus_err
);

    localparam int TW = cnt_width(TIMEOUT);
    localparam int RW = cnt_width(MAX_D_RUN);

    arb_state_t    state_q, state_d;
    arb_gnt_t      gnt_q;
    logic [RW-1:0] d_run_q;
    logic [31:0]   rdata_q;
    logic          err_q;
    logic          bus_we_q;
    logic [31:0]   bus_addr_q;
    logic [31:0]   bus_wdata_q;
    logic [3:0]    bus_wtype_q;
    logic          start;
    logic          pick_if;
    logic          in_busy;
    logic          in_resp;
    logic          tmo_tc;

    assign in_busy = (state_q == ARB_BUSY);
    assign in_resp = (state_q == ARB_RESP);
    assign start   = (state_q == ARB_IDLE) && (if_req || d_req);
    // Fetch wins only when data is idle or data has used up its run budget.
    assign pick_if = if_req && (!d_req || (d_run_q == RW'(MAX_D_RUN)));

    mem_arb_timer #(
        .WIDTH    (TW),
        .TERMINAL (TIMEOUT - 1)
    ) u_tmo (
        .clk      (clk),
        .reset    (reset),
        .clr      (start),
        .en       (in_busy),
        .load     (1'b0),
        .load_val ('0),
        .tc       (tmo_tc)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB_IDLE: if (start) state_d = ARB_BUSY;
            ARB_BUSY: if (bus_ready || tmo_tc) state_d = ARB_RESP;
            ARB_RESP: state_d = ARB_IDLE;
            default:  state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ARB_IDLE;
            gnt_q       <= GNT_IF;
            d_run_q     <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_wtype_q <= '0;
        end else begin
            state_q <= state_d;
            if (start) begin
                err_q <= 1'b0;
                if (pick_if) begin
                    gnt_q       <= GNT_IF;
                    d_run_q     <= '0;
                    bus_we_q    <= 1'b0;
                    bus_addr_q  <= if_addr;
                    bus_wdata_q <= '0;
                    bus_wtype_q <= '0;
                end else begin
                    gnt_q       <= GNT_D;
                    bus_we_q    <= d_we;
                    bus_addr_q  <= d_addr;
                    bus_wdata_q <= d_wdata;
                    bus_wtype_q <= d_wtype;
                    if (!if_req)
                        d_run_q <= '0;
                    else if (d_run_q != RW'(MAX_D_RUN))
                        d_run_q <= d_run_q + RW'(1);
                end
            end
            if (in_busy) begin
                if (bus_ready) begin
                    rdata_q <= bus_rdata;
                end else if (tmo_tc) begin
                    rdata_q <= '0;
                    err_q   <= 1'b1;
                end
            end
        end
    end

    assign bus_req   = in_busy;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign bus_wtype = bus_wtype_q;
    assign if_done   = in_resp && (gnt_q == GNT_IF);
    assign d_done    = in_resp && (gnt_q == GNT_D);
    assign bus_err   = in_resp && err_q;
    assign if_rdata  = if_done ? rdata_q : '0;
    assign d_rdata   = (d_done && !bus_we_q) ? rdata_q : '0;
    assign if_stall  = if_req && !if_done;
    assign d_stall   = d_req && !d_done;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - randomized transaction-timeline checker for mem_port_arbiter
module tb_mem_port_arbiter;

    localparam int T = 8;
    localparam int M = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_done;
    logic        if_stall;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_wtype;
    logic [31:0] d_rdata;
    logic        d_done;
    logic        d_stall;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wtype;
    logic [31:0] bus_rdata;
    logic        bus_ready;
    logic        bus_err;

    always #5 clk = ~clk;

    mem_port_arbiter #(.MAX_D_RUN(M), .TIMEOUT(T)) dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_done   (if_done),
        .if_stall  (if_stall),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_wtype   (d_wtype),
        .d_rdata   (d_rdata),
        .d_done    (d_done),
        .d_stall   (d_stall),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_wtype (bus_wtype),
        .bus_rdata (bus_rdata),
        .bus_ready (bus_ready),
        .bus_err   (bus_err)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Transaction-level reference: one planned bus transaction on a cycle timeline.
    bit          in_txn;
    int          start_at;
    int          kdel;
    int          done_at;
    bit          w_d;
    bit          t_we;
    logic [31:0] t_addr;
    logic [31:0] t_wdata;
    logic [31:0] t_rdata;
    logic [3:0]  t_wtype;
    int          drun;
    bit          if_pend;
    bit          d_pend;

    task automatic run_random(input int ncyc);
        in_txn  = 1'b0;
        drun    = 0;
        if_pend = 1'b0;
        d_pend  = 1'b0;
        if_req  = 1'b0;
        d_req   = 1'b0;
        bus_ready = 1'b0;
        for (int c = 0; c < ncyc; c++) begin
            bit e_busy;
            bit e_if_done;
            bit e_d_done;
            bit e_err;
            int last_busy;
            @(negedge clk);
            if (in_txn && c > done_at) in_txn = 1'b0;
            last_busy = start_at + ((kdel < T) ? kdel : T - 1);
            e_busy    = in_txn && c >= start_at && c <= last_busy;
            e_if_done = in_txn && c == done_at && !w_d;
            e_d_done  = in_txn && c == done_at && w_d;
            e_err     = in_txn && c == done_at && kdel >= T;

            chk("bus_req", bus_req, e_busy);
            chk("if_done", if_done, e_if_done);
            chk("d_done", d_done, e_d_done);
            chk("bus_err", bus_err, e_err);
            chk("if_stall", if_stall, if_req & ~e_if_done);
            chk("d_stall", d_stall, d_req & ~e_d_done);
            if (e_busy) begin
                chk("bus_addr", bus_addr, t_addr);
                chk("bus_we", bus_we, t_we);
                if (w_d) begin
                    chk("bus_wdata", bus_wdata, t_wdata);
                    chk("bus_wtype", bus_wtype, t_wtype);
                end
            end
            if (e_if_done) chk("if_rdata", if_rdata, t_rdata);
            if (e_d_done)  chk("d_rdata", d_rdata, t_we ? 32'h0 : t_rdata);

            if (!if_pend || e_if_done) begin
                if_pend = ($urandom % 4) != 0;
                if_addr = $urandom & 32'hFFFF_FFFC;
            end
            if (!d_pend || e_d_done) begin
                d_pend  = ($urandom % 4) != 0;
                d_we    = $urandom % 2;
                d_addr  = $urandom & 32'hFFFF_FFFC;
                d_wdata = $urandom;
                d_wtype = 4'($urandom);
            end
            if_req = if_pend;
            d_req  = d_pend;

            bus_rdata = $urandom;
            if (e_busy && kdel < T && c == start_at + kdel) begin
                bus_ready = 1'b1;
                t_rdata   = bus_rdata;
            end else if (e_busy) begin
                bus_ready = 1'b0;
            end else begin
                bus_ready = $urandom % 2;
            end

            if (!in_txn && (if_req || d_req)) begin
                w_d = d_req && !(if_req && drun == M);
                if (w_d) drun = if_req ? ((drun < M) ? drun + 1 : M) : 0;
                else     drun = 0;
                t_addr   = w_d ? d_addr : if_addr;
                t_we     = w_d ? d_we : 1'b0;
                t_wdata  = d_wdata;
                t_wtype  = d_wtype;
                t_rdata  = 32'h0;
                start_at = c + 1;
                kdel     = $urandom_range(0, 9);
                done_at  = start_at + 1 + ((kdel < T) ? kdel : T - 1);
                in_txn   = 1'b1;
            end
        end
    endtask

    initial begin
        reset     = 1'b0;
        if_req    = 1'b0;
        if_addr   = '0;
        d_req     = 1'b0;
        d_we      = 1'b0;
        d_addr    = '0;
        d_wdata   = '0;
        d_wtype   = '0;
        bus_rdata = '0;
        bus_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_bus_req", bus_req, 1'b0);
        chk("rst_bus_we", bus_we, 1'b0);
        chk("rst_bus_addr", bus_addr, 32'h0);
        chk("rst_dones", {if_done, d_done, bus_err}, 3'b000);
        reset = 1'b1;

        run_random(600);

        @(negedge clk);
        reset     = 1'b0;
        if_req    = 1'b0;
        d_req     = 1'b0;
        bus_ready = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 32'h0000_0200;
        @(negedge clk);
        chk("pre_rst_bus_req", bus_req, 1'b1);
        #2 reset = 1'b0;
        #1;
        chk("async_rst_bus_req", bus_req, 1'b0);
        chk("async_rst_d_done", d_done, 1'b0);
        chk("async_rst_bus_err", bus_err, 1'b0);
        d_req     = 1'b0;
        bus_ready = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("rst_hold_d_done", d_done, 1'b0);
            chk("rst_hold_bus_req", bus_req, 1'b0);
        end
        reset = 1'b1;

        run_random(400);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
